// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit x^4+x^3+1 LFSR pattern stream.
// It synchronises to the incoming samples, then flags and counts each mismatch against the predicted sequence.
module lfsr_checker #(
  parameter int LOCK_MATCHES = 3,
  parameter int LOSS_MISSES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [3:0]       sample,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] error_count,
  output logic             zero_seen,
  output logic [3:0]       expected
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_MATCHES);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_MISSES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic [3:0]       expected_q, expected_d;
  logic [3:0]       predict;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    error_d     = 1'b0;
    count_d     = count_q;
    zero_d      = zero_q;
    predict     = lfsr_next(prev_q);

    if (sample_valid) begin
      if (sample == 4'd0) zero_d = 1'b1;
      case (state_q)
        SEARCH: begin
          if (sample == 4'd0) begin
            run_d = 4'd0;
          end else if (have_prev_q && sample == predict) begin
            run_d = run_q + 4'd1;
          end else begin
            run_d = 4'd0;
          end
          prev_d      = sample;
          have_prev_d = (sample != 4'd0);
          if (run_d == LOCK_N) begin
            state_d = LOCKED;
            miss_d  = 4'd0;
          end
        end
        LOCKED: begin
          if (sample == predict) begin
            prev_d = sample;
            miss_d = 4'd0;
          end else begin
            // Flywheel on the prediction so a single bad sample costs one error.
            error_d = 1'b1;
            count_d = sat_inc(count_q);
            miss_d  = miss_q + 4'd1;
            prev_d  = predict;
            if (miss_d == LOSS_N) begin
              state_d     = SEARCH;
              run_d       = 4'd0;
              prev_d      = sample;
              have_prev_d = (sample != 4'd0);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear) begin
      count_d = '0;
      zero_d  = 1'b0;
    end

    expected_d = (state_d == LOCKED) ? lfsr_next(prev_d) : 4'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      error_q     <= 1'b0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      expected_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      error_q     <= error_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      expected_q  <= expected_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error       = error_q;
  assign error_count = count_q;
  assign zero_seen   = zero_q;
  assign expected    = expected_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 4-bit LFSR pattern generator. It takes the generator's `result` stream one sample per `sample_valid`, self-synchronises to the sequence, then predicts each next value and counts mismatches. It sits at the sink end of the pattern link, in the board top level or a testbench, so a generator/checker pair gives a pass/fail link test on LEDs.

## Interface
Parameters:
- LOCK_MATCHES, 3: consecutive correct transitions required to declare lock (1..15)
- LOSS_MISSES, 2: consecutive mismatches while locked that drop lock (1..15)
- CNT_W, 16: width of the error counter

Ports:
- clock  in  1  single system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of `error_count` and `zero_seen`
- sample_valid  in  1  `sample` is accepted on this edge
- sample  in  4  received LFSR value
- locked  out  1  checker is synchronised to the sequence
- error  out  1  one-cycle pulse per mismatching sample while locked
- error_count  out  CNT_W  saturating count of errors
- zero_seen  out  1  sticky: an all-zero sample was received
- expected  out  4  predicted next sample while locked, else 0000

## Operation
- Polynomial x^4+x^3+1: next(s) = {s[2:0], s[3]^s[2]}, period 15. From 0001 the sequence is 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001…
- Internal state: `prev[3:0]`, `have_prev`, `run` (match counter), `miss` (miss counter), FSM {SEARCH, LOCKED}.
- Nothing changes on a cycle with `sample_valid`=0, except `clear` and the `error` pulse returning low.
- SEARCH, valid sample:
  - If sample == 0000: run←0, have_prev←0.
  - Else if have_prev and sample == next(prev): run←run+1.
  - Else: run←0.
  - prev←sample, have_prev←1 (unless the sample was zero).
  - When the updated run equals LOCK_MATCHES: go to LOCKED, miss←0.
- LOCKED, valid sample, with exp = next(prev):
  - Match: prev←sample, miss←0.
  - Mismatch (zero included): error pulse, error_count+1, miss←miss+1.
  - On a mismatch prev←exp (flywheel), so one corrupted sample produces exactly one error.
  - When the updated miss equals LOSS_MISSES: go to SEARCH, run←0, prev←sample, have_prev←(sample≠0).
- zero_seen is set by any valid 0000 sample in either state.
- error_count saturates at all-ones and does not wrap.
- clear has priority: if clear and an error occur on the same edge, the result is error_count=0 and zero_seen=0. The `error` pulse still fires, and lock state is unaffected.
- expected = next(prev) registered while LOCKED, 0000 in SEARCH.

## Timing
- All outputs are registered. They reflect the sample accepted at edge N from just after edge N.
- Reset (reset=0, asynchronous): SEARCH, have_prev=0, run=0, miss=0, locked=0, error=0, error_count=0, zero_seen=0, expected=0000. Reset takes effect immediately, including mid-lock. Release is sampled synchronously; the first valid sample after release is treated as a seed.
- Lock latency: with an error-free stream, locked rises after the (LOCK_MATCHES+1)-th valid sample edge.
- Unlock latency: locked falls at the edge of the LOSS_MISSES-th consecutive mismatch. That edge still pulses error and increments the count.
- Valid gaps of any length are transparent: prediction resumes from the last accepted sample.

## Test plan
- Lock: reset, then stream 0001, 0010, 0100, 1001 with valid every cycle (LOCK_MATCHES=3). Required: locked=1 after the 4th edge, expected=0011, error_count=0.
- Single error: locked, send 0111 instead of 0011, then 0110. Required: one error pulse, error_count=1, locked stays 1, 0110 accepted as a match.
- Loss and relock: locked, send two wrong samples (LOSS_MISSES=2). Required: error_count=2, locked=0 after the 2nd edge. Resume the correct sequence: relock 3 matches later.
- Zero and clear: send 0000 in SEARCH. Required: zero_seen=1, run reset. Assert clear on the same edge as a locked error. Required: error_count=0, error pulse still seen.
- Saturation and gaps: CNT_W=2, 5 errors while locked. Required: error_count=3. Valid low for 10 cycles mid-stream. Required: no state change.
- Async reset mid-lock: pull reset low between edges. Required: locked, error, expected and error_count go to 0 immediately.
